// File: rtl/sys_bus_bridge_pkg.sv
// sys_bus_bridge_pkg: shared FSM encodings, default address map and helpers
// for the registered CPU-to-peripheral bridge.
//   state_e          : IDLE / ACCESS / RESP transaction states
//   DEF_*            : default slave windows, word-only mask and timeout
//   idx_w()          : width of a slot index for n slaves (never 0)
package sys_bus_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam int           DEF_N_SLV     = 4;
    localparam logic [127:0] DEF_SLV_BASE  = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
    localparam logic [127:0] DEF_SLV_LAST  = {32'h0000_7F23, 32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_2FFF};
    localparam logic [3:0]   DEF_WORD_ONLY = 4'b1110;
    localparam int           DEF_TIMEOUT   = 15;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_bus_bridge_decoder.sv
// sys_bus_bridge_decoder: combinational address-window decode.
//   addr_i/we_i/byteen_i : access being requested
//   hit_o                : address falls inside some window
//   idx_o                : lowest-index window that matched
//   illegal_o            : sub-word access to a word-only slot
module sys_bus_bridge_decoder
    import sys_bus_bridge_pkg::*;
#(
    parameter int                     N_SLV     = DEF_N_SLV,
    parameter logic [N_SLV*32-1:0]    SLV_BASE  = DEF_SLV_BASE,
    parameter logic [N_SLV*32-1:0]    SLV_LAST  = DEF_SLV_LAST,
    parameter logic [N_SLV-1:0]       WORD_ONLY = DEF_WORD_ONLY,
    localparam int                    IW        = idx_w(N_SLV)
) (
    input  logic [31:0]   addr_i,
    input  logic          we_i,
    input  logic [3:0]    byteen_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o,
    output logic          illegal_o
);

    // Scan from the top so the lowest matching index overwrites the rest.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (addr_i >= SLV_BASE[32*i +: 32] && addr_i <= SLV_LAST[32*i +: 32]) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
        illegal_o = hit_o && WORD_ONLY[idx_o] &&
                    (we_i ? (byteen_i != 4'b1111) : (addr_i[1:0] != 2'b00));
    end

endmodule

// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: registered CPU-to-peripheral bridge with one-hot select,
// wait-state handshake, bus-error reporting and slave timeout.
//   clk, reset (async, active-high)
//   cpu_req/we/addr/byteen/wdata -> request, sampled only in IDLE
//   cpu_busy/done/err/rdata      -> pipeline freeze, completion pulse, fault, read data
//   slv_sel/we/addr/byteen/wdata -> latched access, driven only in ACCESS
//   slv_rdata/slv_ack            -> per-slot read data and completion
module sys_bus_bridge
    import sys_bus_bridge_pkg::*;
#(
    parameter int                     N_SLV     = DEF_N_SLV,
    parameter logic [N_SLV*32-1:0]    SLV_BASE  = DEF_SLV_BASE,
    parameter logic [N_SLV*32-1:0]    SLV_LAST  = DEF_SLV_LAST,
    parameter logic [N_SLV-1:0]       WORD_ONLY = DEF_WORD_ONLY,
    parameter int                     TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [3:0]            cpu_byteen,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [31:0]           cpu_rdata,
    output logic [N_SLV-1:0]      slv_sel,
    output logic                  slv_we,
    output logic [31:0]           slv_addr,
    output logic [3:0]            slv_byteen,
    output logic [31:0]           slv_wdata,
    input  logic [N_SLV*32-1:0]   slv_rdata,
    input  logic [N_SLV-1:0]      slv_ack
);

    localparam int IW = idx_w(N_SLV);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      byteen_q;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            dec_hit, dec_illegal;
    logic [IW-1:0]   dec_idx;
    logic            legal, ack, timeout;

    sys_bus_bridge_decoder #(
        .N_SLV     (N_SLV),
        .SLV_BASE  (SLV_BASE),
        .SLV_LAST  (SLV_LAST),
        .WORD_ONLY (WORD_ONLY)
    ) u_dec (
        .addr_i    (cpu_addr),
        .we_i      (cpu_we),
        .byteen_i  (cpu_byteen),
        .hit_o     (dec_hit),
        .idx_o     (dec_idx),
        .illegal_o (dec_illegal)
    );

    assign legal   = dec_hit && !dec_illegal;
    assign ack     = slv_ack[idx_q];
    assign timeout = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = cpu_req ? (legal ? S_ACCESS : S_RESP) : S_IDLE;
            S_ACCESS: state_d = (ack || timeout) ? S_RESP : S_ACCESS;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else if (state_q == S_IDLE && cpu_req) begin
            err_q <= !legal;
            cnt_q <= '0;
            if (legal) begin
                idx_q    <= dec_idx;
                we_q     <= cpu_we;
                addr_q   <= cpu_addr;
                byteen_q <= cpu_byteen;
                wdata_q  <= cpu_wdata;
            end
        end else if (state_q == S_ACCESS) begin
            if (ack) begin
                if (!we_q) rdata_q <= slv_rdata[idx_q*32 +: 32];
            end else if (timeout) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Slave-side signals are gated by state so they read 0 outside ACCESS.
    always_comb begin
        cpu_busy   = state_q != S_IDLE;
        cpu_done   = state_q == S_RESP;
        cpu_err    = (state_q == S_RESP) && err_q;
        cpu_rdata  = rdata_q;
        slv_sel    = (state_q == S_ACCESS) ? (N_SLV'(1) << idx_q) : '0;
        slv_we     = (state_q == S_ACCESS) && we_q;
        slv_addr   = (state_q == S_ACCESS) ? addr_q : '0;
        slv_byteen = (state_q == S_ACCESS) ? byteen_q : '0;
        slv_wdata  = (state_q == S_ACCESS) ? wdata_q : '0;
    end

endmodule

// File: doc/sys_bus_bridge.md
Name: sys_bus_bridge

Overview:
Parametrised, registered CPU-to-peripheral bridge for the P-series MIPS system. It replaces the purely combinational address decoder with a transaction FSM:
- latches each CPU data access;
- decodes it against N_SLV address windows;
- drives a one-hot select with a wait-state handshake;
- returns read data or a bus error (unmapped address, illegal sub-word access, slave timeout) that the CPU converts into AdEL/AdES.

Parameters:
N_SLV, 4, number of slave windows.
SLV_BASE, {32'h7F20,32'h7F10,32'h7F00,32'h0000}, flat N_SLV*32 vector; slot i = bits [32i+31:32i], inclusive window start.
SLV_LAST, {32'h7F23,32'h7F1B,32'h7F0B,32'h2FFF}, flat N_SLV*32 vector; inclusive window end per slot.
WORD_ONLY, 4'b1110, bit i set means slot i accepts only byteen==4'b1111 on writes and word-aligned reads.
TIMEOUT, 15, maximum ACCESS cycles before error; 0 disables timeout.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  access request, sampled only in IDLE.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  32  byte address.
cpu_byteen  in  4  byte enables.
cpu_wdata  in  32  write data.
cpu_busy  out  1  high whenever state != IDLE; CPU freezes its pipeline.
cpu_done  out  1  one-cycle completion pulse.
cpu_err  out  1  valid with cpu_done; access faulted.
cpu_rdata  out  32  registered read data, valid with cpu_done.
slv_sel  out  N_SLV  one-hot slave select.
slv_we  out  1  latched write enable.
slv_addr  out  32  latched address.
slv_byteen  out  4  latched byte enables.
slv_wdata  out  32  latched write data.
slv_rdata  in  N_SLV*32  flat read-data bus, slot i = [32i+31:32i].
slv_ack  in  N_SLV  per-slave completion; may be combinational in the first ACCESS cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (port reset). On reset, state=IDLE and every output is 0, including slv_sel, cpu_rdata and the internal timeout counter.
- States:
  - IDLE to ACCESS: cpu_req=1 and the decode is legal. Latch addr, we, byteen, wdata and the slot index. Next cycle slv_sel[idx]=1.
  - IDLE to RESP with err: cpu_req=1 and any of the following:
    - no window hit;
    - WORD_ONLY slot with a write whose byteen != 4'b1111;
    - WORD_ONLY slot with a read whose addr[1:0] != 0.
    - No slave is ever selected on this path.
  - ACCESS to RESP: slv_ack[idx]=1. A read latches slv_rdata slot idx into cpu_rdata; a write leaves cpu_rdata unchanged.
  - ACCESS to RESP with err: counter == TIMEOUT-1 without ack (TIMEOUT>0). slv_sel drops on entry to RESP.
  - RESP to IDLE: unconditional. cpu_done=1 for exactly this cycle; cpu_err=1 if flagged.
- Latency:
  - Legal access: req at cycle 0, ACCESS at cycle 1, done at cycle 2 if ack arrives in the first ACCESS cycle, plus one cycle per wait state.
  - Error decode: done at cycle 1.
- Decode rules: window test is base <= addr <= last, unsigned. Overlapping windows resolve to the lowest index. Decode is combinational on cpu_addr in IDLE only.
- Handshake rules:
  - slv_* outputs are stable throughout ACCESS and are 0 outside ACCESS.
  - slv_ack of non-selected slots, or outside ACCESS, is ignored.
  - cpu_req while busy is ignored; the CPU must hold it low or it is re-sampled in the next IDLE.
  - Back-to-back requests: the earliest new acceptance is the IDLE cycle after RESP.
- Counter: width $clog2(TIMEOUT+1). Cleared on entering ACCESS; increments each ACCESS cycle without ack.
- Reset mid-operation: immediate return to IDLE, select dropped, no done pulse.

Decomposition:
- Shared header: state encodings (S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2) and the default window constants as `define macros, alongside the existing address-map defines.
- One sub-module, bus_addr_decoder: combinational, parametrised by N_SLV/SLV_BASE/SLV_LAST/WORD_ONLY. Outputs hit, idx and illegal.

Test Plan:
- Read DM: req addr=0x0000_0104, we=0, slot0 ack at cycle 1 with rdata 0xDEADBEEF -> cpu_done at cycle 2, cpu_rdata=0xDEADBEEF, err=0, slv_sel=4'b0001 only during cycle 1.
- TC1 write with 3 wait states: addr=0x7F04, byteen=1111, wdata=0x10, slot1 ack at the 4th ACCESS cycle -> slv_sel=4'b0010 stable for 4 cycles, done at cycle 5, err=0.
- Illegal access: write addr=0x7F10 byteen=4'b0011 -> no slv_sel ever asserted, done and err at cycle 1. Repeat with addr=0x5000 (unmapped) -> same result.
- Timeout: read 0x7F20 with slot3 never acking -> sel held 15 cycles, then done=1, err=1, cpu_rdata unchanged.
- Reset mid-operation: assert reset during cycle 2 of a stalled TC2 access -> outputs 0 immediately. After release, a new DM read completes normally.
- Busy rule: hold cpu_req=1 continuously with two reads -> second accepted only in the IDLE cycle after the first RESP. Inject a stray slv_ack[2] during a slot0 access -> no effect.
